i2c_ball_rx_slave: RTL and testbench



---
 rtl/i2c_ball_rx_slave.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_ball_rx_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ball_rx_slave.sv
// i2c_ball_rx_slave: write-only I2C slave that receives the 5-byte ball-handoff
//   packet from the opposite board and presents it as decoded ball state.
// Latency: STOP on pins to frame_valid = SYNC_STAGES+2 clk cycles; ACK driven
//   SYNC_STAGES+1 clk cycles after the 8th SCL falling edge.
// Backpressure: none; the slave never stretches SCL, results are one-cycle strobes.
// Ports:
//   clk, reset             system clock (>= 10x SCL), synchronous active-high reset
//   scl, sda_i             raw I2C pins (synchronized internally)
//   sda_oe                 1 = pull SDA low for ACK (open-drain)
//   ball_y, ball_vy, gravity_counter, is_collusion  decoded frame fields
//   frame_valid            one-cycle pulse when the decoded fields update
//   frame_err              one-cycle pulse when a partial/bad frame is discarded
//   busy                   high from START until the transaction ends
// Optional: define BALL_RX_STRICT_EN to reject frames with non-zero reserved bits.
module i2c_ball_rx_slave #(
  parameter logic [7:0] ADDR_BYTE   = 8'hAA,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic       is_collusion,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_WAIT_STOP, S_IGNORE, S_COMMIT
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_full;      // 8 bits shifted, waiting for the 8th falling edge
  logic [2:0]             r_byte_idx;
  // Shadow copies of the payload fields; only the decoded bits are kept.
  logic [1:0]             r_sh_y_hi;
  logic [7:0]             r_sh_y_lo;
  logic [7:0]             r_sh_vy;
  logic [1:0]             r_sh_grav;
  logic                   r_sh_col;
`ifdef BALL_RX_STRICT_EN
  logic                   r_rsv_bad;   // any reserved bit seen set in this frame
`endif

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both samples so a simultaneous SCL/SDA change is not a condition.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_scl_sync      <= '1;
      r_sda_sync      <= '1;
      r_scl_d         <= 1'b1;
      r_sda_d         <= 1'b1;
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_full          <= 1'b0;
      r_byte_idx      <= '0;
      r_sh_y_hi       <= '0;
      r_sh_y_lo       <= '0;
      r_sh_vy         <= '0;
      r_sh_grav       <= '0;
      r_sh_col        <= 1'b0;
`ifdef BALL_RX_STRICT_EN
      r_rsv_bad       <= 1'b0;
`endif
      sda_oe          <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      is_collusion    <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d     <= w_scl;
      r_sda_d     <= w_sda;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (r_state == S_COMMIT) begin
        // One-cycle commit slot after STOP; bus conditions cannot recur this soon.
`ifdef BALL_RX_STRICT_EN
        if (r_rsv_bad) begin
          frame_err <= 1'b1;
        end else
`endif
        begin
          ball_y          <= {r_sh_y_hi, r_sh_y_lo};
          ball_vy         <= r_sh_vy;
          gravity_counter <= r_sh_grav;
          is_collusion    <= r_sh_col;
          frame_valid     <= 1'b1;
        end
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else if (w_start) begin
        // Repeated START discards anything after an ACKed address.
        frame_err <= (r_state == S_ADDR_ACK) || (r_state == S_DATA) ||
                     (r_state == S_DATA_ACK) || (r_state == S_WAIT_STOP);
        r_state   <= S_ADDR;
        busy      <= 1'b1;
        sda_oe    <= 1'b0;
        r_bit_cnt <= '0;
        r_full    <= 1'b0;
`ifdef BALL_RX_STRICT_EN
        r_rsv_bad <= 1'b0;
`endif
      end else if (w_stop) begin
        sda_oe    <= 1'b0;
        r_bit_cnt <= '0;
        r_full    <= 1'b0;
        if (r_state == S_WAIT_STOP) begin
          r_state <= S_COMMIT;
        end else begin
          frame_err <= (r_state == S_ADDR) || (r_state == S_ADDR_ACK) ||
                       (r_state == S_DATA) || (r_state == S_DATA_ACK);
          r_state   <= S_IDLE;
          busy      <= 1'b0;
        end
      end else begin
        if (w_scl_rise && (r_state == S_ADDR || r_state == S_DATA)) begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_full <= 1'b1;
        end
        case (r_state)
          S_ADDR: begin
            if (w_scl_fall && r_full) begin
              r_full <= 1'b0;
              if (r_shift == ADDR_BYTE) begin
                r_state <= S_ADDR_ACK;
                sda_oe  <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
                busy    <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              sda_oe     <= 1'b0;
              r_state    <= S_DATA;
              r_byte_idx <= '0;
              r_bit_cnt  <= '0;
            end
          end
          S_DATA: begin
            if (w_scl_fall && r_full) begin
              r_full  <= 1'b0;
              case (r_byte_idx)
                3'd0: begin
                  r_sh_y_hi <= r_shift[7:6];
`ifdef BALL_RX_STRICT_EN
                  if (|r_shift[5:0]) r_rsv_bad <= 1'b1;
`endif
                end
                3'd1: r_sh_y_lo <= r_shift;
                3'd2: r_sh_vy   <= r_shift;
                3'd3: begin
                  r_sh_grav <= r_shift[1:0];
`ifdef BALL_RX_STRICT_EN
                  if (|r_shift[7:2]) r_rsv_bad <= 1'b1;
`endif
                end
                default: begin
                  r_sh_col <= r_shift[0];
`ifdef BALL_RX_STRICT_EN
                  if (|r_shift[7:1]) r_rsv_bad <= 1'b1;
`endif
                end
              endcase
              r_state <= S_DATA_ACK;
              sda_oe  <= 1'b1;
            end
          end
          S_DATA_ACK: begin
            if (w_scl_fall) begin
              sda_oe     <= 1'b0;
              r_byte_idx <= r_byte_idx + 3'd1;
              r_state    <= (r_byte_idx == 3'd4) ? S_WAIT_STOP : S_DATA;
            end
          end
          default: sda_oe <= 1'b0;  // IDLE, IGNORE, WAIT_STOP: never ACK
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_ball_rx_slave.sv
// tb_i2c_ball_rx_slave: bit-banged I2C master driving directed and random frames
//   into i2c_ball_rx_slave; a frame-level model predicts ACKs and frame events,
//   and a monitor pops the expected events whenever frame_valid/frame_err pulse.
module tb_i2c_ball_rx_slave;

  localparam int         SYNC = 2;
  localparam int         Q    = 4;        // clk cycles per quarter SCL period
  localparam logic [7:0] ADDR = 8'hAA;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       is_collusion;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;

  assign sda_i = sda_m & ~sda_oe;   // open-drain wired-AND
  always #5 clk = ~clk;

  i2c_ball_rx_slave #(.ADDR_BYTE(ADDR), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .scl(scl_m), .sda_i(sda_i), .sda_oe(sda_oe),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .is_collusion(is_collusion), .frame_valid(frame_valid), .frame_err(frame_err),
    .busy(busy)
  );

  typedef struct packed {
    logic       ok;   // 1 = commit expected, 0 = frame_err expected
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] g;
    logic       c;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stop_cyc = 0;
  logic [9:0] m_y = '0;
  logic [7:0] m_vy = '0;
  logic [1:0] m_g = '0;
  logic       m_c = 1'b0;
  bit         pend_open = 1'b0;
  logic [7:0] pend_addr = '0;
  logic [7:0] pend_bytes[$];
  logic [7:0] fb [8];

  function automatic void check(string nm, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Frame-level outcome: what the slave must report when a transaction ends.
  function automatic void resolve(input bit is_stop);
    exp_t e;
    if (!pend_open) return;
    pend_open = 1'b0;
    if (pend_addr != ADDR) return;
    e = '0;
    if (is_stop && pend_bytes.size() >= 5) begin
      e.ok = 1'b1;
`ifdef BALL_RX_STRICT_EN
      if (pend_bytes[0][5:0] != 0 || pend_bytes[3][7:2] != 0 || pend_bytes[4][7:1] != 0)
        e.ok = 1'b0;
`endif
      if (e.ok) begin
        e.y  = {pend_bytes[0][7:6], pend_bytes[1]};
        e.vy = pend_bytes[2];
        e.g  = pend_bytes[3][1:0];
        e.c  = pend_bytes[4][0];
        m_y = e.y; m_vy = e.vy; m_g = e.g; m_c = e.c;
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic bus_start();
    resolve(1'b0);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
    pend_open = 1'b1;
    pend_bytes.delete();
  endtask

  task automatic bus_stop();
    resolve(1'b1);
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait();
    sda_m = 1'b1; stop_cyc = cyc;
    qwait(); qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_addr);
    bit exp_ack;
    if (is_addr) begin
      exp_ack   = (b == ADDR);
      pend_addr = b;
    end else begin
      exp_ack = (pend_addr == ADDR) && (pend_bytes.size() < 5);
      pend_bytes.push_back(b);
    end
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait();
    check(is_addr ? "addr_ack" : "data_ack", 32'(sda_oe), 32'(exp_ack));
    qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic frame(input logic [7:0] a, input int n, input bit do_stop);
    bus_start();
    send_byte(a, 1'b1);
    for (int k = 0; k < n; k++) send_byte(fb[k], 1'b0);
    if (do_stop) bus_stop();
  endtask

  task automatic check_idle();
    check("idle_busy", 32'(busy), 0);
    check("idle_sda_oe", 32'(sda_oe), 0);
    check("hold_ball_y", 32'(ball_y), 32'(m_y));
    check("hold_ball_vy", 32'(ball_vy), 32'(m_vy));
    check("hold_gravity", 32'(gravity_counter), 32'(m_g));
    check("hold_collision", 32'(is_collusion), 32'(m_c));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sda_oe"}, 32'(sda_oe), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_ball_y"}, 32'(ball_y), 0);
    check({tag, "_ball_vy"}, 32'(ball_vy), 0);
    check({tag, "_gravity"}, 32'(gravity_counter), 0);
    check({tag, "_collision"}, 32'(is_collusion), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every frame_valid/frame_err pulse must match the next expected event.
  logic prev_fv = 1'b0;
  logic prev_fe = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && (frame_valid || frame_err)) begin
      check("pulse_one_cycle", 32'({prev_fv & frame_valid, prev_fe & frame_err}), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({frame_valid, frame_err}), 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'({frame_valid, frame_err}), e.ok ? 32'd2 : 32'd1);
        if (e.ok && frame_valid) begin
          check("ball_y", 32'(ball_y), 32'(e.y));
          check("ball_vy", 32'(ball_vy), 32'(e.vy));
          check("gravity_counter", 32'(gravity_counter), 32'(e.g));
          check("is_collusion", 32'(is_collusion), 32'(e.c));
          check("stop_latency", 32'(cyc - stop_cyc), SYNC + 2);
        end
      end
    end
    prev_fv = frame_valid;
    prev_fe = frame_err;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         n;
    bit         stp;
    repeat (4) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reference frame
    fb = '{8'h80, 8'h2C, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b1);
    check_idle();
    check("t1_ball_y_const", 32'(ball_y), 32'h22C);

    // Foreign address: no ACK, no event, outputs hold
    frame(8'hA8, 5, 1'b1);
    check_idle();

    // Short frame: error, outputs hold
    fb = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 3, 1'b1);
    check_idle();

    // Two bytes, repeated START, then a full frame
    frame(ADDR, 2, 1'b0);
    fb = '{8'h40, 8'h10, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b1);
    check_idle();
    check("t4_ball_y_const", 32'(ball_y), 32'h110);

    // Reserved bit in byte 4
    fb = '{8'h80, 8'h2C, 8'h05, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b1);
    check_idle();

    // Extra bytes are NACKed, the first five commit
    fb = '{8'hC0, 8'h7E, 8'h9A, 8'h03, 8'h00, 8'h55, 8'hAA, 8'h00};
    frame(ADDR, 7, 1'b1);
    check_idle();

    // Repeated START in WAIT_STOP discards the frame
    fb = '{8'h40, 8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b0);
    fb = '{8'h00, 8'h33, 8'h44, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b1);
    check_idle();

    // Reset in the middle of data byte 2
    bus_start();
    send_byte(ADDR, 1'b1);
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(i[0]);
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    pend_open = 1'b0;
    pend_bytes.delete();
    m_y = '0; m_vy = '0; m_g = '0; m_c = 1'b0;
    bus_stop();
    fb = '{8'hC0, 8'hA5, 8'h5A, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
    frame(ADDR, 5, 1'b1);
    check_idle();

    // Random frames
    for (int it = 0; it < 20; it++) begin
      a   = ($urandom_range(0, 3) != 0) ? ADDR : 8'($urandom);
      n   = $urandom_range(0, 7);
      stp = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      if ($urandom_range(0, 1) != 0) begin
        fb[0][5:0] = '0;
        fb[3][7:2] = '0;
        fb[4][7:1] = '0;
      end
      frame(a, n, stp);
      if (stp) check_idle();
    end
    if (pend_open) bus_stop();
    check_idle();

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("events_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
